// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding, byte-lane masks and load-extension helpers.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic [31:0] extend8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering for the LSU. Store side turns funct3/address/data into
// BRAM write enables and replicated write data; load side picks and extends
// the addressed byte or halfword. Purely combinational.
// Build option: DMEM_LSU_MISALIGN_TRAP_EN flags misaligned halfword/word
// accesses; without it the low address bits are ignored and misalign is 0.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  we,
    output logic [31:0] din,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] dout,
    output logic [31:0] rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: replicate data across lanes and enable only the target lanes
    always_comb begin
        we  = 4'b0000;
        din = wdata;
        case (funct3)
            F3_B: begin
                din = {4{wdata[7:0]}};
                we  = LANE_B << addr_lo;
            end
            F3_H: begin
                din = {2{wdata[15:0]}};
                we  = LANE_H << {addr_lo[1], 1'b0};
            end
            F3_W: begin
                din = wdata;
                we  = LANE_W;
            end
            default: begin
                din = wdata;
                we  = 4'b0000;
            end
        endcase
    end

    // Misalignment detection, compiled in only when trapping is enabled
    always_comb begin
        misalign = 1'b0;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        case (funct3)
            F3_H, F3_HU: misalign = addr_lo[0];
            F3_W:        misalign = (addr_lo != 2'b00);
            default:     misalign = 1'b0;
        endcase
`endif
    end

    assign ld_byte = dout[8*ld_addr_lo +: 8];
    assign ld_half = ld_addr_lo[1] ? dout[31:16] : dout[15:0];

    // Load path: select the addressed lane and sign- or zero-extend it
    always_comb begin
        rdata = 32'd0;
        case (ld_funct3)
            F3_B:    rdata = extend8(ld_byte, 1'b1);
            F3_BU:   rdata = extend8(ld_byte, 1'b0);
            F3_H:    rdata = extend16(ld_half, 1'b1);
            F3_HU:   rdata = extend16(ld_half, 1'b0);
            F3_W:    rdata = dout;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core memory stage and BRAM port B.
// One request per handshake; errors are answered directly from IDLE and
// never touch the BRAM. Loads wait READ_LATENCY cycles in RDWAIT after the
// BRAM samples the address, then capture doutb.
// Build option: DMEM_LSU_MISALIGN_TRAP_EN (see dmem_lsu_align).
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 1096,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clkb,
    input  logic        rstb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bram_en,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    output logic [3:0]  bram_we,
    input  logic [31:0] bram_dout,
    input  logic        bram_rst_busy
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY - 1);

    state_t      state, state_nxt;
    logic        accept;
    logic        funct_bad;
    logic        req_err;
    logic        misalign;
    logic [3:0]  st_we;
    logic [31:0] st_din;
    logic [31:0] ld_rdata;

    // request attributes held for the load return path
    logic [2:0]  funct3_p0;
    logic [1:0]  lane_p0;
    logic        we_p0;

    logic [1:0]  cnt, cnt_nxt;
    logic        en_nxt;
    logic [3:0]  we_nxt;
    logic [31:0] addr_nxt, din_nxt, rdata_nxt;
    logic        rsp_valid_nxt, rsp_err_nxt;

    assign req_ready = (state == IDLE) && !bram_rst_busy && !rstb;
    assign accept    = req_valid && req_ready;

    dmem_lsu_align u_align (
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .we         (st_we),
        .din        (st_din),
        .misalign   (misalign),
        .ld_funct3  (funct3_p0),
        .ld_addr_lo (lane_p0),
        .dout       (bram_dout),
        .rdata      (ld_rdata)
    );

    // Reject funct3 codes that have no meaning for the requested direction
    always_comb begin
        funct_bad = 1'b0;
        if (req_we)
            funct_bad = (req_funct3 > F3_W);
        else
            funct_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
    end

    assign req_err = funct_bad || (req_addr >= MEM_BYTES) || misalign;

    // Next-state and next registered outputs
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        en_nxt        = 1'b0;
        we_nxt        = 4'b0000;
        addr_nxt      = bram_addr;
        din_nxt       = bram_din;
        rdata_nxt     = 32'd0;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ACC;
                        en_nxt    = 1'b1;
                        addr_nxt  = {req_addr[31:2], 2'b00};
                        if (req_we) begin
                            we_nxt  = st_we;
                            din_nxt = st_din;
                        end
                    end
                end
            end
            ACC: begin
                if (we_p0) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                end else begin
                    state_nxt = RDWAIT;
                    cnt_nxt   = LAT_LAST;
                end
            end
            RDWAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rdata_nxt     = ld_rdata;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clkb) begin
        if (rstb) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            bram_en   <= 1'b0;
            bram_we   <= 4'b0000;
            bram_addr <= 32'd0;
            bram_din  <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bram_en   <= en_nxt;
            bram_we   <= we_nxt;
            bram_addr <= addr_nxt;
            bram_din  <= din_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rdata_nxt;
        end
    end

    // Request attributes captured at acceptance for the load return path
    always_ff @(posedge clkb) begin
        if (accept) begin
            funct3_p0 <= req_funct3;
            lane_p0   <= req_addr[1:0];
            we_p0     <= req_we;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: two instances (READ_LATENCY 1 and 2), each
// with its own behavioural BRAM port model.
module tb_dmem_lsu;

    logic        clkb = 1'b0;
    logic        rstb = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = 2'b00;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata  [2];
    logic [1:0]  rsp_err;
    logic [1:0]  bram_en;
    logic [31:0] bram_addr  [2];
    logic [31:0] bram_din   [2];
    logic [3:0]  bram_we    [2];
    logic [31:0] bram_dout  [2];
    logic [1:0]  bram_rst_busy = 2'b00;

    logic [31:0] mem [2][0:1095];
    logic [31:0] q1 [2];
    logic [31:0] q2 [2];
    int          en_seen [2] = '{0, 0};

    int nerr = 0;
    int nchk = 0;

    logic [31:0] o_rdata, o_addr0, o_din0;
    logic        o_err, o_en0;
    logic [3:0]  o_we0;
    int          o_lat, o_pulses;

    always #5 clkb = ~clkb;

    dmem_lsu #(.MEM_DEPTH(1096), .READ_LATENCY(1)) u_dut1 (
        .clkb(clkb), .rstb(rstb),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .bram_en(bram_en[0]), .bram_addr(bram_addr[0]), .bram_din(bram_din[0]),
        .bram_we(bram_we[0]), .bram_dout(bram_dout[0]), .bram_rst_busy(bram_rst_busy[0])
    );

    dmem_lsu #(.MEM_DEPTH(1096), .READ_LATENCY(2)) u_dut2 (
        .clkb(clkb), .rstb(rstb),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .bram_en(bram_en[1]), .bram_addr(bram_addr[1]), .bram_din(bram_din[1]),
        .bram_we(bram_we[1]), .bram_dout(bram_dout[1]), .bram_rst_busy(bram_rst_busy[1])
    );

    assign bram_dout[0] = q1[0];
    assign bram_dout[1] = q2[1];

    // BRAM port-B models: byte-enable write, registered read, optional 2nd stage
    always @(posedge clkb) begin
        for (int i = 0; i < 2; i++) begin
            int w;
            w = int'(bram_addr[i][12:2]);
            if (bram_en[i]) begin
                en_seen[i] <= en_seen[i] + 1;
                if (w < 1096) begin
                    for (int b = 0; b < 4; b++)
                        if (bram_we[i][b]) mem[i][w][8*b +: 8] <= bram_din[i][8*b +: 8];
                    q1[i] <= mem[i][w];
                end
            end
            q2[i] <= q1[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One handshake plus response wait; results land in the o_* variables
    task automatic do_req(input int idx, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int start_en;
        int waitc;
        @(negedge clkb);
        req_we[idx]     = we;
        req_funct3[idx] = f3;
        req_addr[idx]   = addr;
        req_wdata[idx]  = wdata;
        req_valid[idx]  = 1'b1;
        waitc = 0;
        while (!req_ready[idx] && waitc < 20) begin
            @(negedge clkb);
            waitc++;
        end
        start_en = en_seen[idx];
        @(posedge clkb);
        #1;
        req_valid[idx] = 1'b0;
        o_en0   = bram_en[idx];
        o_we0   = bram_we[idx];
        o_addr0 = bram_addr[idx];
        o_din0  = bram_din[idx];
        o_lat   = -1;
        o_rdata = 32'hx;
        o_err   = 1'bx;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid[idx]) begin
                o_lat   = c;
                o_rdata = rsp_rdata[idx];
                o_err   = rsp_err[idx];
                break;
            end
            @(posedge clkb);
            #1;
        end
        o_pulses = en_seen[idx] - start_en;
    endtask

    task automatic xact(input string tag, input int idx, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        do_req(idx, we, f3, addr, wdata);
        chk({tag, "_lat"}, o_lat, exp_lat);
        chk({tag, "_rdata"}, o_rdata, exp_rdata);
        chk({tag, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
        chk({tag, "_en_pulses"}, o_pulses, exp_err ? 0 : 1);
    endtask

    initial begin
        int pre_en;
        int seen_rsp;
        for (int i = 0; i < 2; i++) begin
            req_funct3[i] = 3'b000;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
        end
        repeat (3) @(posedge clkb);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i), {31'd0, req_ready[i]}, 32'd0);
            chk($sformatf("rst_rsp_valid%0d", i), {31'd0, rsp_valid[i]}, 32'd0);
            chk($sformatf("rst_rsp_err%0d", i), {31'd0, rsp_err[i]}, 32'd0);
            chk($sformatf("rst_rdata%0d", i), rsp_rdata[i], 32'd0);
            chk($sformatf("rst_en%0d", i), {31'd0, bram_en[i]}, 32'd0);
            chk($sformatf("rst_we%0d", i), {28'd0, bram_we[i]}, 32'd0);
            chk($sformatf("rst_addr%0d", i), bram_addr[i], 32'd0);
            chk($sformatf("rst_din%0d", i), bram_din[i], 32'd0);
        end
        @(negedge clkb);
        rstb = 1'b0;

        // write then read back, byte/half loads, on both latencies
        for (int i = 0; i < 2; i++) begin
            int rl;
            rl = i + 1;
            xact($sformatf("sw0_i%0d", i), i, 1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 32'd0, 1'b0, 1);
            chk($sformatf("sw0_we_i%0d", i), {28'd0, o_we0}, 32'h0000000F);
            chk($sformatf("sw0_din_i%0d", i), o_din0, 32'hDEADBEEF);
            chk($sformatf("sw0_en_i%0d", i), {31'd0, o_en0}, 32'd1);
            xact($sformatf("lw0_i%0d", i), i, 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1 + rl);
            xact($sformatf("lb3_i%0d", i), i, 1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFFDE, 1'b0, 1 + rl);
            xact($sformatf("lbu3_i%0d", i), i, 1'b0, 3'b100, 32'h3, 32'h0, 32'h000000DE, 1'b0, 1 + rl);
            xact($sformatf("lhu2_i%0d", i), i, 1'b0, 3'b101, 32'h2, 32'h0, 32'h0000DEAD, 1'b0, 1 + rl);
            xact($sformatf("lb0_i%0d", i), i, 1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFFFFEF, 1'b0, 1 + rl);
            xact($sformatf("lh0_i%0d", i), i, 1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFFBEEF, 1'b0, 1 + rl);
        end

        // sub-word stores
        xact("sb5", 0, 1'b1, 3'b000, 32'h5, 32'h000000AA, 32'd0, 1'b0, 1);
        chk("sb5_addr", o_addr0, 32'h4);
        chk("sb5_we", {28'd0, o_we0}, 32'h2);
        chk("sb5_din", o_din0, 32'hAAAAAAAA);
        xact("sh6", 0, 1'b1, 3'b001, 32'h6, 32'h00001234, 32'd0, 1'b0, 1);
        chk("sh6_we", {28'd0, o_we0}, 32'hC);
        chk("sh6_din", o_din0, 32'h12341234);
        xact("lbu5", 0, 1'b0, 3'b100, 32'h5, 32'h0, 32'h000000AA, 1'b0, 2);
        xact("lhu6", 0, 1'b0, 3'b101, 32'h6, 32'h0, 32'h00001234, 1'b0, 2);

        // error cases
        xact("sw8", 0, 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'd0, 1'b0, 1);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        xact("lhA", 0, 1'b0, 3'b001, 32'hA, 32'h0, 32'd0, 1'b1, 0);
`else
        xact("lhA", 0, 1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFFCAFE, 1'b0, 2);
`endif
        xact("lw_oor", 0, 1'b0, 3'b010, 32'h1120, 32'h0, 32'd0, 1'b1, 0);
        xact("lw_last", 0, 1'b0, 3'b010, 32'h111C, 32'h0, 32'hx, 1'b0, 2);
        xact("ld_f3_011", 0, 1'b0, 3'b011, 32'h0, 32'h0, 32'd0, 1'b1, 0);
        xact("ld_f3_110", 0, 1'b0, 3'b110, 32'h0, 32'h0, 32'd0, 1'b1, 0);
        xact("st_f3_100", 0, 1'b1, 3'b100, 32'h0, 32'h55, 32'd0, 1'b1, 0);
        xact("lw0_after_err", 0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // busy gating
        @(negedge clkb);
        bram_rst_busy[0] = 1'b1;
        req_we[0] = 1'b1; req_funct3[0] = 3'b010; req_addr[0] = 32'h10;
        req_wdata[0] = 32'h11223344; req_valid[0] = 1'b1;
        pre_en = en_seen[0];
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("busy_ready_c%0d", c), {31'd0, req_ready[0]}, 32'd0);
            @(negedge clkb);
        end
        chk("busy_no_en", en_seen[0], pre_en);
        bram_rst_busy[0] = 1'b0;
        #1;
        chk("busy_release_ready", {31'd0, req_ready[0]}, 32'd1);
        @(posedge clkb);
        #1;
        req_valid[0] = 1'b0;
        chk("busy_release_en", {31'd0, bram_en[0]}, 32'd1);
        repeat (3) @(posedge clkb);
        xact("lw10", 0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h11223344, 1'b0, 2);

        // reset during RDWAIT on the latency-2 instance
        @(negedge clkb);
        req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h4; req_valid[1] = 1'b1;
        @(posedge clkb);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clkb);
        @(negedge clkb);
        rstb = 1'b1;
        @(posedge clkb);
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("midrst_rdata", rsp_rdata[1], 32'd0);
        chk("midrst_en", {31'd0, bram_en[1]}, 32'd0);
        chk("midrst_we", {28'd0, bram_we[1]}, 32'd0);
        chk("midrst_addr", bram_addr[1], 32'd0);
        chk("midrst_din", bram_din[1], 32'd0);
        chk("midrst_ready", {31'd0, req_ready[1]}, 32'd0);
        @(negedge clkb);
        rstb = 1'b0;
        seen_rsp = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clkb);
            #1;
            if (rsp_valid[1]) seen_rsp++;
        end
        chk("midrst_no_rsp", seen_rsp, 0);
        xact("lw0_after_rst", 1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
